// File: rtl/btn_event_unit.sv
// Button event capture: synchronises active-low keys and records sticky press/long-press
// flags plus a wrapping press counter per button, cleared by single-cycle pulses.
module btn_event_unit #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned LONG_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_BTN-1:0]       i_btn,
  input  logic [N_BTN-1:0]       i_clr_press,
  input  logic [N_BTN-1:0]       i_clr_long,
  input  logic [N_BTN-1:0]       i_clr_cnt,
  output logic [N_BTN-1:0]       o_btn_level,
  output logic [N_BTN-1:0]       o_press_flag,
  output logic [N_BTN-1:0]       o_long_flag,
  output logic [N_BTN*CNT_W-1:0] o_press_cnt
);

  localparam int unsigned HoldW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] long_q, long_d;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [HoldW-1:0] hold_q  [N_BTN];
  logic [HoldW-1:0] hold_d  [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      press_q <= '0;
      long_q  <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        state_q[k] <= StIdle;
        hold_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1_q <= ~i_btn;
      sync2_q <= sync1_q;
      press_q <= press_d;
      long_q  <= long_d;
      for (int k = 0; k < N_BTN; k++) begin
        state_q[k] <= state_d[k];
        hold_q[k]  <= hold_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Clears are applied first so that a coincident set/increment overrides them.
  always_comb begin
    press_d = press_q & ~i_clr_press;
    long_d  = long_q & ~i_clr_long;
    for (int k = 0; k < N_BTN; k++) begin
      state_d[k] = state_q[k];
      hold_d[k]  = hold_q[k];
      cnt_d[k]   = i_clr_cnt[k] ? '0 : cnt_q[k];
      case (state_q[k])
        StIdle: begin
          if (sync2_q[k]) begin
            state_d[k] = StHeld;
            press_d[k] = 1'b1;
            cnt_d[k]   = cnt_d[k] + CNT_W'(1);
            hold_d[k]  = '0;
          end
        end
        StHeld: begin
          if (!sync2_q[k]) begin
            state_d[k] = StIdle;
            hold_d[k]  = '0;
          end else if (hold_q[k] == HoldLast) begin
            state_d[k] = StLong;
            long_d[k]  = 1'b1;
          end else begin
            hold_d[k] = hold_q[k] + HoldW'(1);
          end
        end
        StLong: begin
          if (!sync2_q[k]) begin
            state_d[k] = StIdle;
          end
        end
        default: state_d[k] = StIdle;
      endcase
    end
  end

  always_comb begin
    o_press_cnt = '0;
    for (int k = 0; k < N_BTN; k++) begin
      o_press_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign o_btn_level  = sync2_q;
  assign o_press_flag = press_q;
  assign o_long_flag  = long_q;

endmodule
